// File: rtl/ctrl_pkg.sv
// Shared control definitions for the pipelined RV32I control unit:
// opcodes, control codes, bundle layouts and the halt FSM states.
package ctrl_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IALU   = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_RTYPE  = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_BR  = 3'b001;
  localparam logic [2:0] ALU_R   = 3'b010;
  localparam logic [2:0] ALU_I   = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;

  localparam logic [2:0] RP_LW  = 3'd0;
  localparam logic [2:0] RP_LH  = 3'd1;
  localparam logic [2:0] RP_LHU = 3'd2;
  localparam logic [2:0] RP_LB  = 3'd3;
  localparam logic [2:0] RP_LBU = 3'd4;

  localparam logic [1:0] WP_SW = 2'd0;
  localparam logic [1:0] WP_SH = 2'd1;
  localparam logic [1:0] WP_SB = 2'd2;

  localparam int EX_W  = 5;
  localparam int MEM_W = 9;
  localparam int WB_W  = 2;

  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int EBK_BIT = 20;

  localparam logic [1:0] DRAIN_CYC = 2'd2;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
    logic       a_source;
  } ex_ctrl_t;

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] read_part;
    logic [1:0] write_part;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } id_ex_t;

  typedef struct packed {
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ex_mem_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Control-unit bus: ID-side inputs from the core, control bundles,
// hazard and forwarding outputs back to the datapath.
interface pipe_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  import ctrl_pkg::*;

  logic [31:0]            id_instr;
  logic                   id_valid;
  logic                   ex_branch_taken;
  logic                   stall;
  logic                   flush_if_id;
  logic [EX_W-1:0]        ex_ctrl;
  logic [MEM_W-1:0]       mem_ctrl;
  logic [WB_W-1:0]        wb_ctrl;
  logic [REG_ADDR_W-1:0]  ex_rd;
  logic [REG_ADDR_W-1:0]  mem_rd;
  logic [REG_ADDR_W-1:0]  wb_rd;
  logic [1:0]             fwd_a;
  logic [1:0]             fwd_b;
  logic                   halted;

  modport master (
    output id_instr, id_valid, ex_branch_taken,
    input  stall, flush_if_id, ex_ctrl, mem_ctrl, wb_ctrl,
    input  ex_rd, mem_rd, wb_rd, fwd_a, fwd_b, halted
  );

  modport slave (
    input  id_instr, id_valid, ex_branch_taken,
    output stall, flush_if_id, ex_ctrl, mem_ctrl, wb_ctrl,
    output ex_rd, mem_rd, wb_rd, fwd_a, fwd_b, halted
  );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Combinational hazard detection and EX operand forwarding selects.
// Unused sources arrive as x0 so they never match a destination.
module hazard_fwd_unit #(
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use1,
  input  logic                  id_use2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic                  stall,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  function automatic logic hit(
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  used
  );
    return used && (rd != '0) && (rd == rs);
  endfunction

  function automatic logic [1:0] sel(
    input logic [REG_ADDR_W-1:0] rs
  );
    if (!FWD_EN)
      return 2'b00;
    if (mem_reg_write && hit(mem_rd, rs, 1'b1))
      return 2'b10;
    if (wb_reg_write && hit(wb_rd, rs, 1'b1))
      return 2'b01;
    return 2'b00;
  endfunction

  logic hit_ex;
  logic hit_mem;
  logic load_use;
  logic raw;

  assign hit_ex  = hit(ex_rd, id_rs1, id_use1)
                 | hit(ex_rd, id_rs2, id_use2);
  assign hit_mem = hit(mem_rd, id_rs1, id_use1)
                 | hit(mem_rd, id_rs2, id_use2);

  assign load_use = ex_mem_read & hit_ex;
  assign raw      = (ex_reg_write & hit_ex)
                  | (mem_reg_write & hit_mem);

  assign stall = load_use | (!FWD_EN & raw);
  assign fwd_a = sel(ex_rs1);
  assign fwd_b = sel(ex_rs2);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined RV32I control: ID decode, ID/EX..MEM/WB control registers,
// hazard/forward hookup and the EBREAK halt-drain FSM.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef logic [REG_ADDR_W-1:0] reg_t;

  state_t     state;
  logic [1:0] cnt;
  logic       halted_q;

  id_ex_t  idex_q;
  ex_mem_t exmem_q;
  wb_ctrl_t memwb_q;
  reg_t    ex_rd_q, mem_rd_q, wb_rd_q;
  reg_t    ex_rs1_q, ex_rs2_q;

  logic [4:0] opcode;
  logic [2:0] f3;
  reg_t       id_rd, id_rs1, id_rs2;
  ex_ctrl_t   d_ex;
  mem_ctrl_t  d_mem;
  wb_ctrl_t   d_wb;
  logic       use1, use2, is_ebreak;

  logic id_live, flush, hz_stall, accept;
  logic unused_bits;

  assign opcode = bus.id_instr[6:2];
  assign f3     = bus.id_instr[F3_LSB +: 3];
  assign id_rd  = bus.id_instr[RD_LSB +: REG_ADDR_W];
  assign id_rs1 = bus.id_instr[RS1_LSB +: REG_ADDR_W];
  assign id_rs2 = bus.id_instr[RS2_LSB +: REG_ADDR_W];
  assign unused_bits = ^{bus.id_instr[31:25], bus.id_instr[1:0]};

  always_comb begin
    d_ex      = '0;
    d_mem     = '0;
    d_wb      = '0;
    use2      = 1'b0;
    is_ebreak = 1'b0;
    use1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC)
          || (opcode == OP_JAL));
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        d_ex.alu_op  = ALU_R;
        d_wb.reg_write = 1'b1;
        use2 = 1'b1;
      end
      (opcode == OP_IALU): begin
        d_ex.alu_op  = ALU_I;
        d_ex.alu_src = 1'b1;
        d_wb.reg_write = 1'b1;
      end
      (opcode == OP_LUI): begin
        d_ex.alu_op  = ALU_LUI;
        d_ex.alu_src = 1'b1;
        d_wb.reg_write = 1'b1;
      end
      (opcode == OP_AUIPC): begin
        d_ex.alu_src  = 1'b1;
        d_ex.a_source = 1'b1;
        d_wb.reg_write = 1'b1;
      end
      (opcode == OP_LOAD): begin
        d_ex.alu_src    = 1'b1;
        d_mem.mem_read  = 1'b1;
        d_wb.reg_write  = 1'b1;
        d_wb.mem_to_reg = 1'b1;
        unique case (f3)
          3'b001:  d_mem.read_part = RP_LH;
          3'b101:  d_mem.read_part = RP_LHU;
          3'b000:  d_mem.read_part = RP_LB;
          3'b100:  d_mem.read_part = RP_LBU;
          default: d_mem.read_part = RP_LW;
        endcase
      end
      (opcode == OP_STORE): begin
        d_ex.alu_src    = 1'b1;
        d_mem.mem_write = 1'b1;
        use2 = 1'b1;
        unique case (f3)
          3'b001:  d_mem.write_part = WP_SH;
          3'b000:  d_mem.write_part = WP_SB;
          default: d_mem.write_part = WP_SW;
        endcase
      end
      (opcode == OP_BRANCH): begin
        d_ex.alu_op  = ALU_BR;
        d_mem.branch = 1'b1;
        use2 = 1'b1;
      end
      (opcode == OP_JAL): begin
        d_ex.alu_src  = 1'b1;
        d_ex.a_source = 1'b1;
        d_mem.jump    = 1'b1;
        d_wb.reg_write = 1'b1;
      end
      (opcode == OP_JALR): begin
        d_ex.alu_src   = 1'b1;
        d_mem.jump     = 1'b1;
        d_wb.reg_write = 1'b1;
      end
      (opcode == OP_SYSTEM): begin
        is_ebreak = bus.id_instr[EBK_BIT];
      end
      default: ;
    endcase
  end

  // Outside RUN the ID slot is a bubble and branches are ignored.
  assign id_live = bus.id_valid && (state == RUN);
  assign flush   = (state == RUN) && bus.ex_branch_taken;
  assign accept  = id_live && !flush && !hz_stall;

  hazard_fwd_unit #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_EN     (FWD_EN)
  ) u_hz (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use1       (id_live & use1),
    .id_use2       (id_live & use2),
    .ex_rd         (ex_rd_q),
    .ex_rs1        (ex_rs1_q),
    .ex_rs2        (ex_rs2_q),
    .ex_reg_write  (idex_q.wb.reg_write),
    .ex_mem_read   (idex_q.mem.mem_read),
    .mem_rd        (mem_rd_q),
    .mem_reg_write (exmem_q.wb.reg_write),
    .wb_rd         (wb_rd_q),
    .wb_reg_write  (memwb_q.reg_write),
    .stall         (hz_stall),
    .fwd_a         (bus.fwd_a),
    .fwd_b         (bus.fwd_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q   <= '0;
      exmem_q  <= '0;
      memwb_q  <= '0;
      ex_rd_q  <= '0;
      mem_rd_q <= '0;
      wb_rd_q  <= '0;
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
    end else begin
      if (accept) begin
        idex_q   <= '{ex: d_ex, mem: d_mem, wb: d_wb};
        ex_rd_q  <= d_wb.reg_write ? id_rd : '0;
        ex_rs1_q <= use1 ? id_rs1 : '0;
        ex_rs2_q <= use2 ? id_rs2 : '0;
      end else begin
        idex_q   <= '0;
        ex_rd_q  <= '0;
        ex_rs1_q <= '0;
        ex_rs2_q <= '0;
      end
      exmem_q  <= '{mem: idex_q.mem, wb: idex_q.wb};
      mem_rd_q <= ex_rd_q;
      memwb_q  <= exmem_q.wb;
      wb_rd_q  <= mem_rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= 2'd0;
      halted_q <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (accept && is_ebreak) begin
            state <= DRAIN;
            cnt   <= 2'd0;
          end
        end
        DRAIN: begin
          cnt <= cnt + 2'd1;
          if (cnt + 2'd1 == DRAIN_CYC) begin
            state    <= HALT;
            halted_q <= 1'b1;
          end
        end
        HALT:    halted_q <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

  assign bus.stall       = (state != RUN) || (hz_stall && !flush);
  assign bus.flush_if_id = flush;
  assign bus.ex_ctrl     = idex_q.ex;
  assign bus.mem_ctrl    = exmem_q.mem;
  assign bus.wb_ctrl     = memwb_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: expectations queued with a due
// cycle at drive time, compared on the falling edge of that cycle.
module tb_pipe_ctrl_unit;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.REG_ADDR_W(5)) ifa ();
  pipe_ctrl_if #(.REG_ADDR_W(5)) ifb ();

  pipe_ctrl_unit #(.REG_ADDR_W(5), .FWD_EN(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  pipe_ctrl_unit #(.REG_ADDR_W(5), .FWD_EN(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  typedef enum int {
    S_STALL, S_FLUSH, S_EX, S_MEM, S_WB,
    S_EXRD, S_MEMRD, S_WBRD, S_FWDA, S_FWDB, S_HALT
  } sel_e;

  typedef struct {
    int          due;
    int          dut;
    sel_e        sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] BEQ    = 32'h0020_8063;
  localparam logic [31:0] LUI13  = 32'h1234_56b7;
  localparam logic [31:0] JAL14  = 32'h0000_076f;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] obs(int d, sel_e s);
    case (s)
      S_STALL: return 32'(d != 0 ? ifb.stall : ifa.stall);
      S_FLUSH: return 32'(d != 0 ? ifb.flush_if_id : ifa.flush_if_id);
      S_EX:    return 32'(d != 0 ? ifb.ex_ctrl : ifa.ex_ctrl);
      S_MEM:   return 32'(d != 0 ? ifb.mem_ctrl : ifa.mem_ctrl);
      S_WB:    return 32'(d != 0 ? ifb.wb_ctrl : ifa.wb_ctrl);
      S_EXRD:  return 32'(d != 0 ? ifb.ex_rd : ifa.ex_rd);
      S_MEMRD: return 32'(d != 0 ? ifb.mem_rd : ifa.mem_rd);
      S_WBRD:  return 32'(d != 0 ? ifb.wb_rd : ifa.wb_rd);
      S_FWDA:  return 32'(d != 0 ? ifb.fwd_a : ifa.fwd_a);
      S_FWDB:  return 32'(d != 0 ? ifb.fwd_b : ifa.fwd_b);
      default: return 32'(d != 0 ? ifb.halted : ifa.halted);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        chk(sb[i].tag, obs(sb[i].dut, sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic want(int d, int dly, sel_e s, logic [31:0] v,
                      string tag);
    exp_t e;
    e.due = cyc + dly;
    e.dut = d;
    e.sel = s;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic step(logic [31:0] ins, logic v, logic b);
    @(posedge clk);
    #1;
    ifa.id_instr = ins;
    ifa.id_valid = v;
    ifa.ex_branch_taken = b;
    ifb.id_instr = '0;
    ifb.id_valid = 1'b0;
    ifb.ex_branch_taken = 1'b0;
  endtask

  task automatic step_b(logic [31:0] ins, logic v);
    @(posedge clk);
    #1;
    ifb.id_instr = ins;
    ifb.id_valid = v;
    ifb.ex_branch_taken = 1'b0;
    ifa.id_instr = '0;
    ifa.id_valid = 1'b0;
    ifa.ex_branch_taken = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) step('0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] r_op(logic [4:0] rd,
      logic [4:0] rs1, logic [4:0] rs2, logic sub);
    return {1'b0, sub, 5'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] ld(logic [2:0] f3,
      logic [4:0] rd, logic [4:0] rs1);
    return {12'd0, rs1, f3, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] st(logic [2:0] f3,
      logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, f3, 5'd0, 7'b0100011};
  endfunction

  function automatic logic [31:0] addi(logic [4:0] rd,
      logic [4:0] rs1);
    return {12'd1, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  initial begin
    ifa.id_instr = '0; ifa.id_valid = 1'b0; ifa.ex_branch_taken = 1'b0;
    ifb.id_instr = '0; ifb.id_valid = 1'b0; ifb.ex_branch_taken = 1'b0;
    idle(2);
    rst = 1'b0;

    // reset state
    step('0, 1'b0, 1'b0);
    want(0, 0, S_STALL, 0, "rst_stall");
    want(0, 0, S_FLUSH, 0, "rst_flush");
    want(0, 0, S_EX, 0, "rst_ex");
    want(0, 0, S_MEM, 0, "rst_mem");
    want(0, 0, S_WB, 0, "rst_wb");
    want(0, 0, S_EXRD, 0, "rst_exrd");
    want(0, 0, S_FWDA, 0, "rst_fwda");
    want(0, 0, S_FWDB, 0, "rst_fwdb");
    want(0, 0, S_HALT, 0, "rst_halt");
    want(1, 0, S_STALL, 0, "rst_stall_b");

    // load-use
    step(ld(3'b010, 5, 1), 1'b1, 1'b0);
    want(0, 0, S_STALL, 0, "lu_ld_nostall");
    want(0, 1, S_EX, 5'b00010, "lu_ld_ex");
    want(0, 1, S_EXRD, 5, "lu_ld_exrd");
    want(0, 2, S_MEM, 9'h040, "lu_ld_mem");
    want(0, 3, S_WB, 2'b11, "lu_ld_wb");
    want(0, 3, S_WBRD, 5, "lu_ld_wbrd");
    step(r_op(6, 5, 2, 1'b0), 1'b1, 1'b0);
    want(0, 0, S_STALL, 1, "lu_stall");
    want(0, 1, S_EX, 0, "lu_bubble");
    step(r_op(6, 5, 2, 1'b0), 1'b1, 1'b0);
    want(0, 0, S_STALL, 0, "lu_release");
    want(0, 1, S_EX, 5'b01000, "lu_add_ex");
    want(0, 1, S_EXRD, 6, "lu_add_exrd");
    want(0, 1, S_FWDA, 2'b01, "lu_fwda");
    want(0, 1, S_FWDB, 2'b00, "lu_fwdb");
    idle(4);

    // forwarding from EX/MEM
    step(r_op(3, 1, 2, 1'b0), 1'b1, 1'b0);
    step(r_op(4, 3, 3, 1'b1), 1'b1, 1'b0);
    want(0, 0, S_STALL, 0, "fw_nostall");
    want(0, 1, S_FWDA, 2'b10, "fw_fwda");
    want(0, 1, S_FWDB, 2'b10, "fw_fwdb");
    want(0, 1, S_MEMRD, 3, "fw_memrd");
    idle(4);

    // no forwarding: two stall cycles
    step_b(r_op(3, 1, 2, 1'b0), 1'b1);
    step_b(r_op(4, 3, 3, 1'b1), 1'b1);
    want(1, 0, S_STALL, 1, "nf_stall1");
    step_b(r_op(4, 3, 3, 1'b1), 1'b1);
    want(1, 0, S_STALL, 1, "nf_stall2");
    step_b(r_op(4, 3, 3, 1'b1), 1'b1);
    want(1, 0, S_STALL, 0, "nf_release");
    want(1, 1, S_EX, 5'b01000, "nf_sub_ex");
    want(1, 1, S_FWDA, 2'b00, "nf_fwda");
    want(1, 1, S_FWDB, 2'b00, "nf_fwdb");
    idle(4);

    // flush, then flush against load-use
    step(ld(3'b010, 7, 1), 1'b1, 1'b1);
    want(0, 0, S_FLUSH, 1, "fl_flush");
    want(0, 0, S_STALL, 0, "fl_stall");
    want(0, 1, S_EX, 0, "fl_ex");
    want(0, 1, S_EXRD, 0, "fl_exrd");
    step(ld(3'b010, 8, 1), 1'b1, 1'b0);
    want(0, 0, S_FLUSH, 0, "fl_noflush");
    want(0, 1, S_EX, 5'b00010, "fl_ld_ex");
    step(r_op(9, 8, 8, 1'b0), 1'b1, 1'b1);
    want(0, 0, S_FLUSH, 1, "fllu_flush");
    want(0, 0, S_STALL, 0, "fllu_stall");
    want(0, 1, S_EX, 0, "fllu_ex");
    idle(4);

    // x0 destination never hazards
    step(ld(3'b010, 0, 1), 1'b1, 1'b0);
    step(r_op(1, 0, 0, 1'b0), 1'b1, 1'b0);
    want(0, 0, S_STALL, 0, "x0_stall");
    want(0, 1, S_FWDA, 0, "x0_fwda");
    want(0, 1, S_FWDB, 0, "x0_fwdb");
    idle(4);

    // part codes and other opcodes
    step(ld(3'b001, 10, 1), 1'b1, 1'b0);
    want(0, 2, S_MEM, 9'h044, "lh_mem");
    step(ld(3'b100, 11, 1), 1'b1, 1'b0);
    want(0, 2, S_MEM, 9'h050, "lbu_mem");
    step(ld(3'b011, 12, 1), 1'b1, 1'b0);
    want(0, 2, S_MEM, 9'h040, "ldbad_mem");
    step(st(3'b000, 2, 3), 1'b1, 1'b0);
    want(0, 1, S_EX, 5'b00010, "sb_ex");
    want(0, 2, S_MEM, 9'h022, "sb_mem");
    step(st(3'b001, 2, 3), 1'b1, 1'b0);
    want(0, 2, S_MEM, 9'h021, "sh_mem");
    step(st(3'b011, 2, 3), 1'b1, 1'b0);
    want(0, 2, S_MEM, 9'h020, "stbad_mem");
    want(0, 3, S_WB, 0, "st_wb");
    step(BEQ, 1'b1, 1'b0);
    want(0, 1, S_EX, 5'b00100, "beq_ex");
    want(0, 2, S_MEM, 9'h100, "beq_mem");
    step(JAL14, 1'b1, 1'b0);
    want(0, 1, S_EX, 5'b00011, "jal_ex");
    want(0, 2, S_MEM, 9'h080, "jal_mem");
    want(0, 3, S_WB, 2'b10, "jal_wb");
    step(LUI13, 1'b1, 1'b0);
    want(0, 1, S_EX, 5'b10010, "lui_ex");
    want(0, 3, S_WB, 2'b10, "lui_wb");
    idle(4);

    // halt drain
    step(addi(1, 0), 1'b1, 1'b0);
    want(0, 3, S_WB, 2'b10, "h_wb1");
    step(addi(2, 0), 1'b1, 1'b0);
    want(0, 3, S_WB, 2'b10, "h_wb2");
    step(addi(3, 0), 1'b1, 1'b0);
    want(0, 3, S_WB, 2'b10, "h_wb3");
    want(0, 3, S_WBRD, 3, "h_wbrd3");
    step(EBREAK, 1'b1, 1'b0);
    want(0, 0, S_STALL, 0, "h_accept");
    want(0, 1, S_STALL, 1, "h_drain1");
    want(0, 1, S_EX, 0, "h_ebk_bubble");
    want(0, 2, S_STALL, 1, "h_drain2");
    want(0, 2, S_HALT, 0, "h_not_yet");
    want(0, 3, S_HALT, 1, "h_halted");
    want(0, 3, S_STALL, 1, "h_stall");
    want(0, 3, S_WB, 0, "h_wb_empty");
    idle(3);
    step(addi(5, 0), 1'b1, 1'b1);
    want(0, 0, S_FLUSH, 0, "h_br_ignored");
    want(0, 0, S_STALL, 1, "h_stall_kept");
    want(0, 1, S_EX, 0, "h_ex_bubble");
    want(0, 1, S_HALT, 1, "h_sticky");

    // reset while halted
    step('0, 1'b0, 1'b0);
    rst = 1'b1;
    want(0, 1, S_HALT, 0, "hr_halt");
    want(0, 1, S_STALL, 0, "hr_stall");
    step('0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1);

    // reset mid-drain with loads in flight
    step(ld(3'b010, 5, 1), 1'b1, 1'b0);
    step(ld(3'b010, 6, 2), 1'b1, 1'b0);
    step(EBREAK, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
    want(0, 0, S_STALL, 1, "dr_draining");
    rst = 1'b1;
    want(0, 1, S_EX, 0, "dr_ex");
    want(0, 1, S_MEM, 0, "dr_mem");
    want(0, 1, S_WB, 0, "dr_wb");
    want(0, 1, S_HALT, 0, "dr_halt");
    want(0, 1, S_STALL, 0, "dr_stall");
    step('0, 1'b0, 1'b0);
    rst = 1'b0;
    step(addi(1, 0), 1'b1, 1'b0);
    want(0, 0, S_STALL, 0, "dr_run");
    want(0, 1, S_EX, 5'b01110, "dr_addi_ex");
    idle(4);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

- Pipelined successor to the combinational RV32I decoder.
- Decodes the instruction in ID and carries EX/MEM/WB control bundles and destination registers through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use and RAW hazards, generates forwarding selects, applies branch flushes, and runs a halt-drain FSM on EBREAK.
- Sits between the IF/ID register and the datapath stage registers; the datapath holds only data.

## Interface
- REG_ADDR_W, 5: register-index width.
- FWD_EN, 1: 1 = forwarding active, stall only on load-use; 0 = fwd selects held 0, stall on any RAW against ID/EX or EX/MEM.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- id_instr  in  32  instruction in ID.
- id_valid  in  1  id_instr is real; 0 = bubble.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- stall  out  1  hold PC and IF/ID.
- flush_if_id  out  1  clear IF/ID.
- ex_ctrl  out  5  {alu_op[2:0], alu_src, a_source} from ID/EX.
- mem_ctrl  out  9  {branch, jump, mem_read, mem_write, read_part[2:0], write_part[1:0]} from EX/MEM.
- wb_ctrl  out  2  {reg_write, mem_to_reg} from MEM/WB.
- ex_rd, mem_rd, wb_rd  out  REG_ADDR_W each  destination per stage.
- fwd_a, fwd_b  out  2 each  operand-A/B source in EX: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- halted  out  1  core stopped; sticky until rst.

## Operation
**Decode** uses opcode[6:2]. Unlisted fields are 0.
- R-type 01100: alu_op 010, reg_write.
- I-ALU 00100: alu_op 011, alu_src, reg_write.
- LUI 01101: alu_op 100, alu_src, reg_write.
- AUIPC 00101: alu_src, a_source, reg_write.
- Load 00000: mem_read, mem_to_reg, alu_src, reg_write. read_part = LW 0, LH 1, LHU 2, LB 3, LBU 4; any other funct3 gives 0.
- Store 01000: mem_write, alu_src. write_part = SW 0, SH 1, SB 2; other funct3 gives 0.
- Branch 11000: branch, alu_op 001.
- JAL 11011: jump, alu_src, a_source, reg_write.
- JALR 11001: jump, alu_src, reg_write.
- SYSTEM 11100: bit20=1 (EBREAK) is the halt trigger; bit20=0 is a NOP.
- FENCE and unknown opcodes decode as NOP.

**Source usage.**
- rs1 is used by all opcodes except LUI, AUIPC and JAL.
- rs2 is used by R, store and branch.
- x0 never matches any destination.

**Hazards.**
- Load-use: ID/EX mem_read, ex_rd≠0, and ex_rd equals a used ID source → stall.
- FWD_EN=0: additionally stall when a used ID source equals ex_rd or mem_rd and that stage's reg_write=1.
- Forwarding, per operand: select 10 if EX/MEM reg_write, mem_rd≠0 and mem_rd equals the EX-stage source. Otherwise select 01 under the same test against MEM/WB. EX/MEM has priority.
- The block tracks rs1/rs2 of the ID/EX instruction internally.

**FSM:** RUN, DRAIN, HALT.
- RUN→DRAIN when id_valid, the instruction is EBREAK, and there is no flush or stall that cycle. The EBREAK itself enters ID/EX as a bubble; the drain counter is cleared to 0.
- DRAIN: stall=1, ID treated as bubble, counter increments. Transition to HALT when the counter reaches 2.
- HALT: stall=1, halted=1, all stages receive bubbles.
- ex_branch_taken is ignored in DRAIN and HALT.

## Timing
- **Reset:** all control registers, rd registers and tracked sources are 0 (bubble). State RUN, counter 0, halted 0. Consequently stall, flush_if_id and fwd_a/fwd_b are 0.
- **Combinational outputs:** stall, flush_if_id, fwd_a and fwd_b are combinational from the inputs and stage registers. All other outputs are registered.
- **Normal flow:** a decoded bundle appears on ex_ctrl 1 cycle after sampling in ID, on mem_ctrl after 2, on wb_ctrl after 3.
- **Stall:** ID/EX loads a bubble; EX/MEM and MEM/WB advance.
- **Flush:** flush_if_id = ex_branch_taken (in RUN). ID/EX loads a bubble.
- **Simultaneous events:**
  - Flush beats stall.
  - Flush beats the EBREAK trigger; state stays RUN.
- **Halt latency:** halted rises exactly 3 cycles after the cycle EBREAK is accepted in ID. By then the three older instructions have left MEM/WB.
- **Reset mid-drain or in HALT:** returns to RUN on the next edge.

## Structure
- Package ctrl_pkg holds:
  - opcode constants;
  - ALUOp codes;
  - read_part/write_part codes;
  - bundle widths and field offsets;
  - the RUN/DRAIN/HALT state enum.
- One sub-module, hazard_fwd_unit, is purely combinational: stall and fwd selects from the ID sources and per-stage rd/reg_write/mem_read.
- The decoder, pipeline registers and FSM live in pipe_ctrl_unit.

## Test plan
- **Load-use:** LW x5,0(x1) then ADD x6,x5,x2 → stall=1 for 1 cycle. The ADD reaches EX one cycle late with fwd_a=01.
- **Forwarding:** ADD x3,x1,x2 then SUB x4,x3,x3 → no stall; fwd_a=fwd_b=10 while SUB is in EX. With FWD_EN=0 → 2 stall cycles.
- **Flush:** ex_branch_taken=1 while a load is in ID → flush_if_id=1 and ex_ctrl=0 next cycle. Also assert load-use on the same cycle → flush wins.
- **Halt:** ADDI, ADDI, ADDI, EBREAK → halted=1 three cycles after EBREAK is in ID. The three ADDIs complete WB; stall stays 1.
- **x0:** LW x0 then ADD x1,x0,x0 → no stall, fwd=00.
- **Reset:** assert rst in DRAIN with loads in flight → next cycle all bundles are 0, halted=0, RUN. Also cover LH/LBU/SB part codes and undefined funct3 → 0.
